// File: rtl/schmitt_trigger_ctrl.sv
// schmitt_trigger_ctrl
//   Sequencing and configuration controller for an 8-bit Schmitt trigger
//   datapath. It owns the trigger thresholds, forwards samples into the
//   trigger, registers the trigger output, and produces edge pulses plus
//   saturating rise/fall event counters.
//
// Handshake rule (both cfg_* and smp_*): a transfer happens on a rising
// clock edge where valid && ready are both high. Valid may be raised or
// dropped at any time. Ready depends only on controller state, never on
// valid.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   cfg_valid/cfg_hi/cfg_lo  threshold-pair request
//   cfg_ready                controller can accept a pair
//   cfg_err                  one-cycle pulse: last accepted pair rejected
//   smp_valid/smp_data       sample stream
//   smp_ready                controller can accept a sample
//   st_in_val/st_maxi/st_mini  drive the trigger instance
//   st_out                   trigger output
//   level                    registered st_out
//   edge_rise/edge_fall      one-cycle pulses on changes of level
//   rise_cnt/fall_cnt        saturating event counters
//   cnt_clr                  synchronous counter clear
//   state_q (internal)       RUN/APPLY state, visible for checkers

module schmitt_trigger_ctrl #(
    parameter int             W      = 8,
    parameter int             CNT_W  = 16,
    parameter logic [W-1:0]   RST_HI = 8'd12,
    parameter logic [W-1:0]   RST_LO = 8'd6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [W-1:0]     cfg_hi,
    input  logic [W-1:0]     cfg_lo,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             smp_valid,
    input  logic [W-1:0]     smp_data,
    output logic             smp_ready,
    output logic [W-1:0]     st_in_val,
    output logic [W-1:0]     st_maxi,
    output logic [W-1:0]     st_mini,
    input  logic             st_out,
    output logic             level,
    output logic             edge_rise,
    output logic             edge_fall,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    input  logic             cnt_clr
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             cfg_err_q, cfg_err_d;
    logic [W-1:0]     in_val_q, in_val_d;
    logic [W-1:0]     maxi_q, maxi_d;
    logic [W-1:0]     mini_q, mini_d;
    logic             level_q, level_d;
    logic             edge_rise_q, edge_rise_d;
    logic             edge_fall_q, edge_fall_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;

    logic run;
    logic cfg_acc;
    logic smp_acc;
    logic cfg_ok;

    // Both streams stall during APPLY so no sample meets a half-updated pair.
    assign run     = (state_q == ST_RUN);
    assign cfg_acc = cfg_valid && run;
    assign smp_acc = smp_valid && run;
    assign cfg_ok  = (cfg_lo < cfg_hi);

    always_comb begin
        state_d     = state_q;
        cfg_err_d   = 1'b0;
        in_val_d    = in_val_q;
        maxi_d      = maxi_q;
        mini_d      = mini_q;

        case (state_q)
            ST_RUN: begin
                if (cfg_acc) begin
                    if (cfg_ok) begin
                        maxi_d  = cfg_hi;
                        mini_d  = cfg_lo;
                        state_d = ST_APPLY;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_APPLY: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        // A sample accepted together with a new pair lands on the same edge,
        // so it is first evaluated against the new thresholds.
        if (smp_acc) begin
            in_val_d = smp_data;
        end

        level_d     = st_out;
        edge_rise_d = st_out & ~level_q;
        edge_fall_d = ~st_out & level_q;

        // Clear wins over a same-cycle increment; the pulse itself is unaffected.
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        if (cnt_clr) begin
            rise_cnt_d = '0;
            fall_cnt_d = '0;
        end else begin
            if (edge_rise_q && (rise_cnt_q != {CNT_W{1'b1}})) begin
                rise_cnt_d = rise_cnt_q + CNT_W'(1);
            end
            if (edge_fall_q && (fall_cnt_q != {CNT_W{1'b1}})) begin
                fall_cnt_d = fall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cfg_err_q   <= 1'b0;
            in_val_q    <= '0;
            maxi_q      <= RST_HI;
            mini_q      <= RST_LO;
            level_q     <= 1'b0;
            edge_rise_q <= 1'b0;
            edge_fall_q <= 1'b0;
            rise_cnt_q  <= '0;
            fall_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cfg_err_q   <= cfg_err_d;
            in_val_q    <= in_val_d;
            maxi_q      <= maxi_d;
            mini_q      <= mini_d;
            level_q     <= level_d;
            edge_rise_q <= edge_rise_d;
            edge_fall_q <= edge_fall_d;
            rise_cnt_q  <= rise_cnt_d;
            fall_cnt_q  <= fall_cnt_d;
        end
    end

    assign cfg_ready = run;
    assign smp_ready = run;
    assign cfg_err   = cfg_err_q;
    assign st_in_val = in_val_q;
    assign st_maxi   = maxi_q;
    assign st_mini   = mini_q;
    assign level     = level_q;
    assign edge_rise = edge_rise_q;
    assign edge_fall = edge_fall_q;
    assign rise_cnt  = rise_cnt_q;
    assign fall_cnt  = fall_cnt_q;

endmodule

// File: tb/tb_schmitt_trigger_ctrl.sv
// Bench for schmitt_trigger_ctrl: two instances (16-bit and 2-bit counters)
// share one stimulus stream and one hysteresis trigger model driving st_out.
// A cycle-level behavioural model predicts all outputs; directed scenarios
// pin the model with hand-computed literals, then a random phase follows.

module tb_schmitt_trigger_ctrl;

    localparam int MAXW = 65535;
    localparam int MAXN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_hi = '0;
    logic [7:0] cfg_lo = '0;
    logic       smp_valid = 1'b0;
    logic [7:0] smp_data = '0;
    logic       cnt_clr = 1'b0;
    logic       st_out;

    logic        cfg_ready_w, cfg_err_w, smp_ready_w, level_w, rise_w, fall_w;
    logic [7:0]  in_w, maxi_w, mini_w;
    logic [15:0] rcnt_w, fcnt_w;
    logic        cfg_ready_n, cfg_err_n, smp_ready_n, level_n, rise_n, fall_n;
    logic [7:0]  in_n, maxi_n, mini_n;
    logic [1:0]  rcnt_n, fcnt_n;

    always #5 clk = ~clk;

    schmitt_trigger_ctrl #(.W(8), .CNT_W(16)) dut_w (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_hi(cfg_hi), .cfg_lo(cfg_lo),
        .cfg_ready(cfg_ready_w), .cfg_err(cfg_err_w),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready_w),
        .st_in_val(in_w), .st_maxi(maxi_w), .st_mini(mini_w), .st_out(st_out),
        .level(level_w), .edge_rise(rise_w), .edge_fall(fall_w),
        .rise_cnt(rcnt_w), .fall_cnt(fcnt_w), .cnt_clr(cnt_clr)
    );

    schmitt_trigger_ctrl #(.W(8), .CNT_W(2)) dut_n (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_hi(cfg_hi), .cfg_lo(cfg_lo),
        .cfg_ready(cfg_ready_n), .cfg_err(cfg_err_n),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready_n),
        .st_in_val(in_n), .st_maxi(maxi_n), .st_mini(mini_n), .st_out(st_out),
        .level(level_n), .edge_rise(rise_n), .edge_fall(fall_n),
        .rise_cnt(rcnt_n), .fall_cnt(fcnt_n), .cnt_clr(cnt_clr)
    );

    // Hysteresis trigger seen by the controller.
    logic trig_hold;
    assign st_out = (in_w > maxi_w) ? 1'b1 : (in_w < mini_w) ? 1'b0 : trig_hold;
    always @(posedge clk) trig_hold <= rst ? 1'b0 : st_out;

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Cycle-indexed view: everything visible in a cycle is a function of what
    // was presented on the preceding edge.
    int m_busy, m_err, m_in, m_maxi, m_mini, m_level, m_rise, m_fall, m_hold;
    int rc_w, fc_w, rc_n, fc_n;
    int s1, s2;
    bit started = 0;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clk) begin
        int trig;
        bit open;
        if (rst) begin
            started = 1;
            m_busy = 0; m_err = 0; m_in = 0; m_maxi = 12; m_mini = 6;
            m_level = 0; m_rise = 0; m_fall = 0; m_hold = 0;
            rc_w = 0; fc_w = 0; rc_n = 0; fc_n = 0;
            s1 = -1; s2 = -1;
        end else begin
            trig = (m_in > m_maxi) ? 1 : (m_in < m_mini) ? 0 : m_hold;
            if (cnt_clr) begin
                rc_w = 0; fc_w = 0; rc_n = 0; fc_n = 0;
            end else begin
                rc_w = sat(rc_w + m_rise, MAXW); fc_w = sat(fc_w + m_fall, MAXW);
                rc_n = sat(rc_n + m_rise, MAXN); fc_n = sat(fc_n + m_fall, MAXN);
            end
            m_rise  = (trig == 1 && m_level == 0) ? 1 : 0;
            m_fall  = (trig == 0 && m_level == 1) ? 1 : 0;
            m_level = trig;
            m_hold  = trig;
            open    = (m_busy == 0);
            m_err   = (open && cfg_valid && !(cfg_lo < cfg_hi)) ? 1 : 0;
            s2 = s1;
            s1 = (open && smp_valid) ? int'(smp_data) : -1;
            if (open && smp_valid) m_in = smp_data;
            if (open && cfg_valid && (cfg_lo < cfg_hi)) begin
                m_maxi = cfg_hi; m_mini = cfg_lo; m_busy = 1;
            end else begin
                m_busy = 0;
            end
        end
    end

    // ---------------- compare process ----------------
    int rise_seen, fall_seen, rise_src, fall_src;

    always @(negedge clk) begin
        if (started) begin
            chk("cfg_ready_w", cfg_ready_w, 1 - m_busy);
            chk("smp_ready_w", smp_ready_w, 1 - m_busy);
            chk("cfg_err_w",   cfg_err_w,   m_err);
            chk("st_in_val_w", in_w,        m_in);
            chk("st_maxi_w",   maxi_w,      m_maxi);
            chk("st_mini_w",   mini_w,      m_mini);
            chk("level_w",     level_w,     m_level);
            chk("edge_rise_w", rise_w,      m_rise);
            chk("edge_fall_w", fall_w,      m_fall);
            chk("rise_cnt_w",  rcnt_w,      rc_w);
            chk("fall_cnt_w",  fcnt_w,      fc_w);
            chk("cfg_ready_n", cfg_ready_n, 1 - m_busy);
            chk("smp_ready_n", smp_ready_n, 1 - m_busy);
            chk("cfg_err_n",   cfg_err_n,   m_err);
            chk("st_in_val_n", in_n,        m_in);
            chk("st_maxi_n",   maxi_n,      m_maxi);
            chk("st_mini_n",   mini_n,      m_mini);
            chk("level_n",     level_n,     m_level);
            chk("edge_rise_n", rise_n,      m_rise);
            chk("edge_fall_n", fall_n,      m_fall);
            chk("rise_cnt_n",  rcnt_n,      rc_n);
            chk("fall_cnt_n",  fcnt_n,      fc_n);
            if (rise_w) begin rise_seen++; rise_src = s2; end
            if (fall_w) begin fall_seen++; fall_src = s2; end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic r, input logic cv, input logic [7:0] hi,
                        input logic [7:0] lo, input logic sv, input logic [7:0] sd,
                        input logic clr);
        @(posedge clk);
        #1;
        rst = r; cfg_valid = cv; cfg_hi = hi; cfg_lo = lo;
        smp_valid = sv; smp_data = sd; cnt_clr = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ramp();
        for (int v = 0; v <= 30; v++) step(0, 0, 0, 0, 1, 8'(v), 0);
        for (int v = 30; v >= 0; v--) step(0, 0, 0, 0, 1, 8'(v), 0);
        idle(4);
    endtask

    task automatic clear_marks();
        rise_seen = 0; fall_seen = 0; rise_src = -1; fall_src = -1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        clear_marks();
        // 1. reset
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_maxi", maxi_w, 12);
        chk("t1_mini", mini_w, 6);
        chk("t1_in_val", in_w, 0);
        chk("t1_level", level_w, 0);
        chk("t1_rise_cnt", rcnt_w, 0);
        chk("t1_cfg_ready", cfg_ready_w, 1);
        chk("t1_smp_ready", smp_ready_w, 1);

        // 2. default thresholds ramp
        clear_marks();
        ramp();
        chk("t2_rise_seen", rise_seen, 1);
        chk("t2_rise_src", rise_src, 13);
        chk("t2_fall_seen", fall_seen, 1);
        chk("t2_fall_src", fall_src, 5);
        chk("t2_rise_cnt", rcnt_w, 1);
        chk("t2_fall_cnt", fcnt_w, 1);

        // 3. new pair 20/10 with samples held valid
        step(0, 1, 8'd20, 8'd10, 1, 8'd0, 0);
        step(0, 0, 0, 0, 1, 8'd0, 0);
        @(negedge clk);
        chk("t3_apply_cfg_ready", cfg_ready_w, 0);
        chk("t3_apply_smp_ready", smp_ready_w, 0);
        chk("t3_apply_maxi", maxi_w, 20);
        chk("t3_apply_mini", mini_w, 10);
        step(0, 0, 0, 0, 1, 8'd0, 0);
        @(negedge clk);
        chk("t3_after_cfg_ready", cfg_ready_w, 1);
        chk("t3_after_smp_ready", smp_ready_w, 1);
        clear_marks();
        ramp();
        chk("t3_rise_src", rise_src, 21);
        chk("t3_fall_src", fall_src, 9);
        chk("t3_rise_cnt", rcnt_w, 2);
        chk("t3_fall_cnt", fcnt_w, 2);

        // 4. rejected pairs
        step(0, 1, 8'd10, 8'd10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4a_err", cfg_err_w, 1);
        chk("t4a_ready", cfg_ready_w, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4a_err_width", cfg_err_w, 0);
        step(0, 1, 8'd5, 8'd9, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4b_err", cfg_err_w, 1);
        chk("t4b_ready", cfg_ready_w, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4b_err_width", cfg_err_w, 0);
        chk("t4_maxi", maxi_w, 20);
        chk("t4_mini", mini_w, 10);

        // 5. saturation on the 2-bit instance, then clear vs rise
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 1, 8'd30, 0);
            idle(1);
            step(0, 0, 0, 0, 1, 8'd0, 0);
            idle(1);
        end
        idle(3);
        chk("t5_rise_cnt_n", rcnt_n, 3);
        chk("t5_fall_cnt_n", fcnt_n, 3);
        chk("t5_rise_cnt_w", rcnt_w, 7);
        step(0, 0, 0, 0, 1, 8'd30, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("t5_clr_pulse", rise_w, 1);
        idle(1);
        @(negedge clk);
        chk("t5_clr_rise_n", rcnt_n, 0);
        chk("t5_clr_rise_w", rcnt_w, 0);
        chk("t5_clr_fall_w", fcnt_w, 0);

        // 6. reset during APPLY
        step(0, 1, 8'd40, 8'd30, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_apply_maxi", maxi_w, 40);
        chk("t6_apply_ready", cfg_ready_w, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_maxi", maxi_w, 12);
        chk("t6_mini", mini_w, 6);
        chk("t6_ready", cfg_ready_w, 1);
        chk("t6_in_val", in_w, 0);

        // random phase
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0),
                 8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 40)),
                 ($urandom_range(0, 49) == 0));
        end
        idle(3);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
